// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider datapath: one shift-subtract step per enable.
module div_iter
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [32:0] trial;

    // rem stays below the divisor, so a borrow in bit 32 means "does not fit"
    assign trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (en) begin
            if (!trial[32]) begin
                rem_q <= trial[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= {rem_q[30:0], quo_q[31]};
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    assign quo = quo_q;
    assign rem = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute-stage unit: 2-cycle multiply, 34-cycle radix-2 divide,
// single-cycle divide-by-zero and signed-overflow results.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            startE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic [4:0]      waddrE,
    input  logic            FlushE,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      waddrM
);

    md_state_e   state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  wa_q, wa_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  waddrM_q, waddrM_d;

    logic        div_load, div_en;
    logic [31:0] div_quo, div_rem;
    logic        sgn_in, ovf_in;
    logic [31:0] dvd_in, dvs_in;

    logic        a_sx, b_sx;
    logic signed [63:0] ax, bx, prod;
    logic        q_neg, r_neg;
    logic [31:0] q_fix, r_fix;

    assign sgn_in = ~funct3E[0];
    assign ovf_in = sgn_in & (opA == INT_MIN) & (opB == 32'hFFFF_FFFF);
    assign dvd_in = sgn_in ? abs32(opA) : opA;
    assign dvs_in = sgn_in ? abs32(opB) : opB;

    assign a_sx = ((f3_q == OP_MULH) | (f3_q == OP_MULHSU)) & a_q[31];
    assign b_sx = (f3_q == OP_MULH) & b_q[31];
    assign ax   = {{32{a_sx}}, a_q};
    assign bx   = {{32{b_sx}}, b_q};
    assign prod = ax * bx;

    assign q_neg = ~f3_q[0] & (a_q[31] ^ b_q[31]);
    assign r_neg = ~f3_q[0] & a_q[31];
    assign q_fix = q_neg ? (~div_quo + 32'd1) : div_quo;
    assign r_fix = r_neg ? (~div_rem + 32'd1) : div_rem;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        f3_d     = f3_q;
        wa_d     = wa_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        waddrM_d = waddrM_q;
        div_load = 1'b0;
        div_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (startE && !FlushE) begin
                    a_d  = opA;
                    b_d  = opB;
                    f3_d = funct3E;
                    wa_d = waddrE;
                    if (!funct3E[2]) begin
                        state_d = MUL;
                    end else if (opB == '0) begin
                        state_d  = DONE;
                        result_d = funct3E[1] ? opA : 32'hFFFF_FFFF;
                        waddrM_d = waddrE;
                    end else if (ovf_in) begin
                        state_d  = DONE;
                        result_d = funct3E[1] ? 32'd0 : INT_MIN;
                        waddrM_d = waddrE;
                    end else begin
                        state_d  = DIV;
                        div_load = 1'b1;
                        cnt_d    = 5'(DIV_ITERS - 1);
                    end
                end
            end
            MUL: begin
                result_d = (f3_q == OP_MUL) ? prod[31:0] : prod[63:32];
                waddrM_d = wa_q;
                state_d  = DONE;
            end
            DIV: begin
                div_en = 1'b1;
                if (cnt_q == '0) state_d = FIX;
                else cnt_d = cnt_q - 5'd1;
            end
            FIX: begin
                result_d = f3_q[1] ? r_fix : q_fix;
                waddrM_d = wa_q;
                state_d  = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A flush discards the op and leaves the last completed result intact
        if (FlushE) begin
            state_d  = IDLE;
            result_d = result_q;
            waddrM_d = waddrM_q;
            div_load = 1'b0;
            div_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            f3_q     <= '0;
            wa_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            waddrM_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            f3_q     <= f3_d;
            wa_q     <= wa_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            waddrM_q <= waddrM_d;
        end
    end

    div_iter u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load),
        .en       (div_en),
        .dividend (dvd_in),
        .divisor  (dvs_in),
        .quo      (div_quo),
        .rem      (div_rem)
    );

    assign busy   = (state_q == MUL) | (state_q == DIV) | (state_q == FIX)
                  | ((state_q == IDLE) & startE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign waddrM = waddrM_q;

endmodule
